// File: rtl/regfile_pkg.sv
// Shared constants, FSM state type and boot-value helper for the multi-port register file.
// The boot-value helper works on BOOT_W-bit values; data widths up to BOOT_W bits are supported.
package regfile_pkg;

    localparam int unsigned DEF_DW        = 32;
    localparam int unsigned DEF_DEPTH     = 32;
    localparam int unsigned DEF_NUM_VALID = 24;
    localparam int unsigned DEF_BOOT0_VAL = 1;
    localparam int unsigned DEF_SP_IDX    = 17;
    localparam int unsigned DEF_SP_VAL    = 2;
    localparam int unsigned BOOT_W        = 64;

    typedef enum logic [0:0] {
        RF_IDLE  = 1'b0,
        RF_CLEAR = 1'b1
    } rf_state_t;

    // Register 0 takes priority when SP_IDX is also 0.
    function automatic logic [BOOT_W-1:0] boot_val(
        input int unsigned       idx,
        input int unsigned       sp_idx,
        input logic [BOOT_W-1:0] boot0,
        input logic [BOOT_W-1:0] sp_val
    );
        logic [BOOT_W-1:0] val_s;
        if (idx == 32'd0) begin
            val_s = boot0;
        end else if (idx == sp_idx) begin
            val_s = sp_val;
        end else begin
            val_s = {BOOT_W{1'b0}};
        end
        return val_s;
    endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Write, read, and clear-control bundle between the datapath (master) and the register file (slave).
interface regfile_mp_if #(
    parameter int DW     = 32,
    parameter int AW     = 5,
    parameter int NUM_RD = 2
);
    logic                 we;
    logic [AW-1:0]        waddr;
    logic [DW-1:0]        wdata;
    logic [NUM_RD*AW-1:0] raddr;
    logic [NUM_RD*DW-1:0] rdata;
    logic                 clr_req;
    logic                 busy;
    logic                 clr_done;

    modport master (
        output we, waddr, wdata, raddr, clr_req,
        input  rdata, busy, clr_done
    );

    modport slave (
        input  we, waddr, wdata, raddr, clr_req,
        output rdata, busy, clr_done
    );
endinterface

// File: rtl/regfile_clear_fsm.sv
// Sequential clear engine: walks every implemented register once, restoring its boot value.
module regfile_clear_fsm
    import regfile_pkg::*;
#(
    parameter int NUM_VALID = 24,
    parameter int AW        = 5
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_req,
    output logic          busy,
    output logic          clr_done,
    output logic          clr_we,
    output logic [AW-1:0] clr_idx,
    output logic          wr_block
);
    localparam int CW = (NUM_VALID > 1) ? $clog2(NUM_VALID) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(NUM_VALID - 1);

    rf_state_t     state_r, state_s;
    logic [CW-1:0] cnt_r, cnt_s;
    logic          busy_r, busy_s;
    logic          done_r, done_s;
    logic          clr_we_s;

    // State, counter and registered status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= RF_IDLE;
            cnt_r   <= {CW{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
        end
    end

    // Next state; a request arriving mid-clear is simply not looked at.
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        busy_s   = busy_r;
        done_s   = 1'b0;
        clr_we_s = 1'b0;
        case (state_r)
            RF_IDLE: begin
                if (clr_req) begin
                    state_s = RF_CLEAR;
                    cnt_s   = {CW{1'b0}};
                    busy_s  = 1'b1;
                end else begin
                    busy_s  = 1'b0;
                end
            end
            RF_CLEAR: begin
                clr_we_s = 1'b1;
                if (cnt_r == LAST_IDX) begin
                    state_s = RF_IDLE;
                    cnt_s   = {CW{1'b0}};
                    busy_s  = 1'b0;
                    done_s  = 1'b1;
                end else begin
                    cnt_s   = cnt_r + CW'(1);
                end
            end
            default: begin
                state_s = RF_IDLE;
                cnt_s   = {CW{1'b0}};
                busy_s  = 1'b0;
            end
        endcase
    end

    assign busy     = busy_r;
    assign clr_done = done_r;
    assign clr_we   = clr_we_s;
    assign clr_idx  = AW'(cnt_r);
    assign wr_block = busy_r;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-read-port register file with optional write bypass and a hardware clear engine.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int                DW        = DEF_DW,
    parameter int                DEPTH     = DEF_DEPTH,
    parameter int                NUM_VALID = DEF_NUM_VALID,
    parameter int                NUM_RD    = 2,
    parameter int                BYPASS    = 1,
    parameter logic [BOOT_W-1:0] BOOT0_VAL = BOOT_W'(DEF_BOOT0_VAL),
    parameter int                SP_IDX    = DEF_SP_IDX,
    parameter logic [BOOT_W-1:0] SP_VAL    = BOOT_W'(DEF_SP_VAL)
)(
    input  logic         clk,
    input  logic         rst,
    regfile_mp_if.slave  bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] NV_LIM = (AW + 1)'(NUM_VALID);
    localparam bit BYP_EN = (BYPASS != 32'sd0);

    logic          clr_we_s;
    logic [AW-1:0] clr_idx_s;
    logic          wr_block_s;
    logic          busy_s;
    logic          clr_done_s;
    logic          waddr_ok_s;
    logic          usr_we_s;
    logic          bypass_s;
    logic [DW-1:0] mem_s [DEPTH];
    logic [NUM_RD*DW-1:0] rdata_s;

    regfile_clear_fsm #(
        .NUM_VALID (NUM_VALID),
        .AW        (AW)
    ) u_clear_fsm (
        .clk      (clk),
        .rst      (rst),
        .clr_req  (bus.clr_req),
        .busy     (busy_s),
        .clr_done (clr_done_s),
        .clr_we   (clr_we_s),
        .clr_idx  (clr_idx_s),
        .wr_block (wr_block_s)
    );

    assign waddr_ok_s = ({1'b0, bus.waddr} < NV_LIM);
    assign usr_we_s   = bus.we && waddr_ok_s && !wr_block_s;
    assign bypass_s   = BYP_EN && bus.we && waddr_ok_s && !wr_block_s;

    for (genvar g = 0; g < NUM_VALID; g++) begin : g_reg
        localparam logic [DW-1:0] BOOT_V = DW'(boot_val(g, SP_IDX, BOOT0_VAL, SP_VAL));
        logic [DW-1:0] q_r;

        // One storage word; the clear engine wins over a user write.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                q_r <= BOOT_V;
            end else if (clr_we_s && (clr_idx_s == AW'(g))) begin
                q_r <= BOOT_V;
            end else if (usr_we_s && (bus.waddr == AW'(g))) begin
                q_r <= bus.wdata;
            end else begin
                q_r <= q_r;
            end
        end

        assign mem_s[g] = q_r;
    end

    // Unimplemented indices are tied to zero so reads of them return 0.
    for (genvar g = NUM_VALID; g < DEPTH; g++) begin : g_unimpl
        assign mem_s[g] = {DW{1'b0}};
    end

    // Per-port read mux; bypass only fires for a matching, accepted write.
    always_comb begin
        rdata_s = {(NUM_RD*DW){1'b0}};
        for (int p = 0; p < NUM_RD; p++) begin
            if (bypass_s && (bus.waddr == bus.raddr[p*AW +: AW])) begin
                rdata_s[p*DW +: DW] = bus.wdata;
            end else begin
                rdata_s[p*DW +: DW] = mem_s[bus.raddr[p*AW +: AW]];
            end
        end
    end

    assign bus.rdata    = rdata_s;
    assign bus.busy     = busy_s;
    assign bus.clr_done = clr_done_s;

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: bypassing and non-bypassing instances share stimulus and are checked
// against a directed table, hand-written clear sequences, and a random run against an array model.
module tb_regfile_mp;
    import regfile_pkg::*;

    localparam int DW    = 32;
    localparam int DEPTH = 32;
    localparam int AW    = 5;
    localparam int NV    = 24;
    localparam int NRD   = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          we;
    logic          clr_req;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic [AW-1:0] ra0;
    logic [AW-1:0] ra1;

    regfile_mp_if #(.DW(DW), .AW(AW), .NUM_RD(NRD)) if_b ();
    regfile_mp_if #(.DW(DW), .AW(AW), .NUM_RD(NRD)) if_n ();

    assign if_b.we = we;  assign if_b.waddr = waddr;  assign if_b.wdata = wdata;
    assign if_b.raddr = {ra1, ra0};  assign if_b.clr_req = clr_req;
    assign if_n.we = we;  assign if_n.waddr = waddr;  assign if_n.wdata = wdata;
    assign if_n.raddr = {ra1, ra0};  assign if_n.clr_req = clr_req;

    regfile_mp #(.DW(DW), .DEPTH(DEPTH), .NUM_VALID(NV), .NUM_RD(NRD), .BYPASS(1))
        dut_b (.clk(clk), .rst(rst), .bus(if_b));
    regfile_mp #(.DW(DW), .DEPTH(DEPTH), .NUM_VALID(NV), .NUM_RD(NRD), .BYPASS(0))
        dut_n (.clk(clk), .rst(rst), .bus(if_n));

    always #5 clk = ~clk;

    int            checks   = 0;
    int            failures = 0;
    logic [DW-1:0] model [DEPTH];
    int            clr_pos;
    logic          mdone;

    typedef struct {
        logic          we;
        logic [AW-1:0] waddr;
        logic [DW-1:0] wdata;
        logic [AW-1:0] ra0;
        logic [AW-1:0] ra1;
        logic [DW-1:0] e0b;
        logic [DW-1:0] e0n;
        logic [DW-1:0] e1b;
        logic [DW-1:0] e1n;
    } vec_t;
    vec_t tbl [10];

    function automatic logic [DW-1:0] tb_boot(input int i);
        if (i == 0)  return 32'd1;
        if (i == 17) return 32'd2;
        return 32'd0;
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: actual=%h expected=%h", name, $time, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a, input bit byp);
        if (int'(a) >= NV) return 32'd0;
        if (byp && clr_pos < 0 && we && waddr == a) return wdata;
        return model[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) model[i] = (i < NV) ? tb_boot(i) : 32'd0;
        clr_pos = -1;
        mdone   = 1'b0;
    endtask

    // Effect of one rising edge on the abstract state.
    task automatic model_edge();
        mdone = 1'b0;
        if (clr_pos >= 0) begin
            model[clr_pos] = tb_boot(clr_pos);
            clr_pos++;
            if (clr_pos == NV) begin
                clr_pos = -1;
                mdone   = 1'b1;
            end
        end else begin
            if (we && int'(waddr) < NV) model[waddr] = wdata;
            if (clr_req) clr_pos = 0;
        end
    endtask

    task automatic check_all();
        chk("busy_b", DW'(if_b.busy), DW'(clr_pos >= 0));
        chk("busy_n", DW'(if_n.busy), DW'(clr_pos >= 0));
        chk("done_b", DW'(if_b.clr_done), DW'(mdone));
        chk("done_n", DW'(if_n.clr_done), DW'(mdone));
        chk("rd0_b", if_b.rdata[DW-1:0], exp_rd(ra0, 1'b1));
        chk("rd1_b", if_b.rdata[2*DW-1:DW], exp_rd(ra1, 1'b1));
        chk("rd0_n", if_n.rdata[DW-1:0], exp_rd(ra0, 1'b0));
        chk("rd1_n", if_n.rdata[2*DW-1:DW], exp_rd(ra1, 1'b0));
    endtask

    // Inputs are set at posedge+1; outputs are sampled at posedge+3.
    task automatic tick(input bit do_chk);
        if (do_chk) begin
            #2;
            check_all();
        end
        @(posedge clk);
        model_edge();
        #1;
    endtask

    initial begin
        #1000000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_cnt;
        int done_cnt;

        tbl[0] = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd17, 32'd1,        32'd1, 32'd2,        32'd2};
        tbl[1] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd24, 32'd0,        32'd0, 32'd0,        32'd0};
        tbl[2] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd31, 32'hDEADBEEF, 32'd0, 32'd0,        32'd0};
        tbl[3] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF};
        tbl[4] = '{1'b1, 5'd26, 32'h1234,     5'd26, 5'd0,  32'd0,        32'd0, 32'd1,        32'd1};
        tbl[5] = '{1'b0, 5'd0,  32'h0,        5'd26, 5'd23, 32'd0,        32'd0, 32'd0,        32'd0};
        tbl[6] = '{1'b1, 5'd0,  32'hA5A5A5A5, 5'd0,  5'd17, 32'hA5A5A5A5, 32'd1, 32'd2,        32'd2};
        tbl[7] = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd1,  32'hA5A5A5A5, 32'hA5A5A5A5, 32'd0, 32'd0};
        tbl[8] = '{1'b1, 5'd23, 32'hCAFEF00D, 5'd23, 5'd23, 32'hCAFEF00D, 32'd0, 32'hCAFEF00D, 32'd0};
        tbl[9] = '{1'b1, 5'd24, 32'hFFFFFFFF, 5'd24, 5'd23, 32'd0,        32'd0, 32'hCAFEF00D, 32'hCAFEF00D};

        rst = 1'b1; we = 1'b0; clr_req = 1'b0; waddr = '0; wdata = '0; ra0 = '0; ra1 = '0;
        model_reset();
        #1;
        chk("rst_busy", DW'(if_b.busy), 32'd0);
        chk("rst_done", DW'(if_b.clr_done), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int a = 0; a < DEPTH; a++) begin
            ra0 = AW'(a);
            ra1 = AW'(DEPTH - 1 - a);
            #1;
            chk("boot_p0", if_b.rdata[DW-1:0], (a < NV) ? tb_boot(a) : 32'd0);
            chk("boot_p1", if_n.rdata[2*DW-1:DW], (DEPTH - 1 - a < NV) ? tb_boot(DEPTH - 1 - a) : 32'd0);
        end
        chk("boot_busy", DW'(if_n.busy), 32'd0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 10; i++) begin
            we = tbl[i].we; waddr = tbl[i].waddr; wdata = tbl[i].wdata;
            ra0 = tbl[i].ra0; ra1 = tbl[i].ra1;
            #2;
            chk($sformatf("tbl%0d_rd0_b", i), if_b.rdata[DW-1:0], tbl[i].e0b);
            chk($sformatf("tbl%0d_rd0_n", i), if_n.rdata[DW-1:0], tbl[i].e0n);
            chk($sformatf("tbl%0d_rd1_b", i), if_b.rdata[2*DW-1:DW], tbl[i].e1b);
            chk($sformatf("tbl%0d_rd1_n", i), if_n.rdata[2*DW-1:DW], tbl[i].e1n);
            chk($sformatf("tbl%0d_busy", i), DW'(if_b.busy), 32'd0);
            tick(1'b0);
        end

        // Clear with writes attempted while busy and a second request mid-clear.
        we = 1'b1; waddr = 5'd3; wdata = 32'h55; tick(1'b1);
        waddr = 5'd23; tick(1'b1);
        we = 1'b0; ra0 = 5'd3; ra1 = 5'd23; clr_req = 1'b1; tick(1'b1);
        clr_req = 1'b0;
        busy_cnt = 0;
        done_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            we      = (clr_pos >= 0);
            waddr   = (c % 2 == 0) ? 5'd3 : 5'd23;
            wdata   = 32'h77;
            clr_req = (c == 5);
            ra0     = AW'($urandom_range(0, 31));
            ra1     = AW'($urandom_range(0, 31));
            #2;
            check_all();
            if (if_b.busy) busy_cnt++;
            if (if_b.clr_done) done_cnt++;
            @(posedge clk);
            model_edge();
            #1;
        end
        chk("clr_busy_cycles", DW'(busy_cnt), 32'd24);
        chk("clr_done_pulses", DW'(done_cnt), 32'd1);
        we = 1'b0; clr_req = 1'b0; ra0 = 5'd3; ra1 = 5'd23;
        #2;
        chk("clr_r3", if_b.rdata[DW-1:0], 32'd0);
        chk("clr_r23", if_n.rdata[2*DW-1:DW], 32'd0);
        ra0 = 5'd0; ra1 = 5'd17;
        #1;
        chk("clr_r0", if_n.rdata[DW-1:0], 32'd1);
        chk("clr_r17", if_b.rdata[2*DW-1:DW], 32'd2);
        @(posedge clk); model_edge(); #1;

        // Clear request together with a write to register 0.
        we = 1'b1; waddr = 5'd0; wdata = 32'd9; clr_req = 1'b1; ra0 = 5'd0; ra1 = 5'd17;
        tick(1'b1);
        we = 1'b0; clr_req = 1'b0;
        #2;
        chk("simul_r0_k", if_b.rdata[DW-1:0], 32'd9);
        chk("simul_r0_k_n", if_n.rdata[DW-1:0], 32'd9);
        @(posedge clk); model_edge(); #1;
        #2;
        chk("simul_r0_k1", if_b.rdata[DW-1:0], 32'd1);
        chk("simul_r0_k1_n", if_n.rdata[DW-1:0], 32'd1);
        @(posedge clk); model_edge(); #1;
        for (int c = 0; c < 40 && clr_pos >= 0; c++) tick(1'b1);
        tick(1'b1);

        // Reset in the middle of a clear.
        clr_req = 1'b1; tick(1'b1);
        clr_req = 1'b0;
        repeat (10) tick(1'b1);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk("midrst_busy_b", DW'(if_b.busy), 32'd0);
        chk("midrst_busy_n", DW'(if_n.busy), 32'd0);
        for (int a = 0; a < NV; a++) begin
            ra0 = AW'(a);
            ra1 = AW'(NV - 1 - a);
            #1;
            chk("midrst_p0", if_b.rdata[DW-1:0], tb_boot(a));
            chk("midrst_p1", if_n.rdata[2*DW-1:DW], tb_boot(NV - 1 - a));
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        done_cnt = 0;
        for (int c = 0; c < 30; c++) begin
            ra0 = AW'($urandom_range(0, 31));
            ra1 = AW'($urandom_range(0, 31));
            #2;
            if (if_b.clr_done) done_cnt++;
            tick(1'b0);
        end
        chk("midrst_no_done", DW'(done_cnt), 32'd0);

        // Random traffic against the model.
        for (int c = 0; c < 400; c++) begin
            we      = 1'($urandom_range(0, 1));
            waddr   = AW'($urandom_range(0, 31));
            wdata   = $urandom;
            ra0     = ($urandom_range(0, 1) == 0) ? waddr : AW'($urandom_range(0, 31));
            ra1     = AW'($urandom_range(0, 31));
            clr_req = ($urandom_range(0, 49) == 0);
            tick(1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
